audio_dac_serializer: RTL and testbench

- Transmit end of the codec audio-out path: takes the write side driven by the pitch-shift datapath and serializes it to the WM8731 DAC.
- Inputs: `left_channel_audio_out` / `right_channel_audio_out` plus the `write_audio_out` strobe.
- Buffers sample pairs in a FIFO and shifts them out on AUD_DACDAT, left-justified, MSB first.
- Frame timing comes from codec-mastered AUD_BCLK/AUD_DACLRCK. Exposes `audio_out_allowed` backpressure.

---
 rtl/audio_dac_serializer.sv | 176 +++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// Purpose: buffers stereo sample pairs and shifts them MSB first, left-justified, onto the WM8731 DAC pin.
// Latency: AUD_DACDAT shows the MSB 4 CLOCK_50 cycles after the DACLRCK pin edge; each shift lands 4 cycles after a BCLK fall.
// Backpressure: audio_out_allowed drops while the FIFO holds FIFO_DEPTH pairs; a write while it is low is dropped and sets overflow.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 128,
    parameter int FIFO_AW    = 7
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    output logic                  audio_out_allowed,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [FIFO_AW:0]      fifo_used,
    output logic                  underrun,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        LEFT       = 2'd1,
        RIGHT      = 2'd2
    } state_e;

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

    // Codec clock synchronisers plus history flops for edge detection.
    logic bclk_meta_q, bclk_sync_q, bclk_hist_q;
    logic lrck_meta_q, lrck_sync_q, lrck_hist_q;
    // Counts the first cycles after reset; edges are ignored until the history flop
    // holds a real pin sample, so a pin that is already high at release is not an edge.
    logic [1:0] prime_q;

    logic                    sync_ok;
    logic                    bclk_fall, lrck_rise, lrck_fall;

    // FIFO storage and bookkeeping.
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]      wptr_q, rptr_q;
    logic [FIFO_AW:0]        count_q;
    logic [2*DATA_WIDTH-1:0] rd_dat;
    logic                    fifo_empty;
    logic                    push, push_blocked, pop;

    // Serialiser state.
    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   pair_q, pair_d;
    logic                    dacdat_q;
    logic                    underrun_q, overflow_q, underrun_set;

    // Bring codec clocks into the CLOCK_50 domain and track the priming window.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_meta_q <= 1'b0;
            bclk_sync_q <= 1'b0;
            bclk_hist_q <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_sync_q <= 1'b0;
            lrck_hist_q <= 1'b0;
            prime_q     <= 2'd0;
        end else begin
            bclk_meta_q <= AUD_BCLK;
            bclk_sync_q <= bclk_meta_q;
            bclk_hist_q <= bclk_sync_q;
            lrck_meta_q <= AUD_DACLRCK;
            lrck_sync_q <= lrck_meta_q;
            lrck_hist_q <= lrck_sync_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign sync_ok   = (prime_q == 2'd3);
    assign bclk_fall = sync_ok & ~bclk_sync_q &  bclk_hist_q;
    assign lrck_rise = sync_ok &  lrck_sync_q & ~lrck_hist_q;
    assign lrck_fall = sync_ok & ~lrck_sync_q &  lrck_hist_q;

    // Allowed is held low during reset and follows the registered fill level afterwards.
    assign audio_out_allowed = (prime_q != 2'd0) && (count_q != DEPTH_C);
    assign fifo_empty        = (count_q == '0);
    assign push              = write_audio_out &  audio_out_allowed & ~clear_audio_out_memory;
    assign push_blocked      = write_audio_out & ~audio_out_allowed & ~clear_audio_out_memory;
    assign rd_dat            = mem_q[rptr_q];

    // Pair storage; left sample in the upper half.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wptr_q] <= {left_channel_audio_out, right_channel_audio_out};
        end
    end

    // Frame sequencing, half-frame loads and bit shifting; a frame-clock edge beats a BCLK shift.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        pair_d       = pair_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        if (lrck_rise) begin
            state_d = LEFT;
            if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = rd_dat[2*DATA_WIDTH-1:DATA_WIDTH];
                pair_d  = rd_dat[DATA_WIDTH-1:0];
            end else begin
                shift_d      = '0;
                pair_d       = '0;
                underrun_set = 1'b1;
            end
        end else if (lrck_fall && (state_q == LEFT)) begin
            state_d = RIGHT;
            shift_d = pair_q;
        end else if (bclk_fall) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Serialiser registers; the output pin is the registered shift MSB, muted while waiting for a frame.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_FRAME;
            shift_q  <= '0;
            pair_q   <= '0;
            dacdat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            pair_q   <= pair_d;
            dacdat_q <= (state_q == WAIT_FRAME) ? 1'b0 : shift_q[DATA_WIDTH-1];
        end
    end

    // FIFO pointers, fill level and sticky flags; clear empties the FIFO and wins over everything here.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear_audio_out_memory) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
                default: count_q <= count_q;
            endcase
            underrun_q <= underrun_q | underrun_set;
            overflow_q <= overflow_q | push_blocked;
        end
    end

    assign AUD_DACDAT = dacdat_q;
    assign fifo_used  = count_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Purpose: self-checking bench for audio_dac_serializer with a codec-master BCLK/DACLRCK model.
// Latency: bits are sampled at each BCLK rising edge, 8 CLOCK_50 cycles after the falling edge.
// Backpressure: a queue model of the FIFO predicts accepted pairs, overflow and underrun.
module tb_audio_dac_serializer;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [DW-1:0] left_dat;
    logic [DW-1:0] right_dat;
    logic          write;
    logic          allowed;
    logic          aud_bclk;
    logic          aud_daclrck;
    logic          dacdat;
    logic [AW:0]   used;
    logic          underrun;
    logic          overflow;

    int            n_checks;
    int            n_pass;
    logic [63:0]   exp_q[$];

    audio_dac_serializer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .FIFO_AW   (AW)
    ) dut (
        .CLOCK_50              (clk),
        .reset_n               (rst_n),
        .clear_audio_out_memory(clear),
        .left_channel_audio_out(left_dat),
        .right_channel_audio_out(right_dat),
        .write_audio_out       (write),
        .audio_out_allowed     (allowed),
        .AUD_BCLK              (aud_bclk),
        .AUD_DACLRCK           (aud_daclrck),
        .AUD_DACDAT            (dacdat),
        .fifo_used             (used),
        .underrun              (underrun),
        .overflow              (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle write; the model stores the pair only if it has room.
    task automatic write_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        left_dat  = l;
        right_dat = r;
        write     = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
    endtask

    // One stereo frame of hb BCLK periods per half. Optionally injects a write
    // on the exact cycle the DUT acts on the DACLRCK rising edge.
    task automatic run_frame(input int hb, input bit inj,
                             input logic [DW-1:0] inj_l, input logic [DW-1:0] inj_r,
                             output logic [63:0] exp_pair,
                             output logic [DW-1:0] lw, output logic [DW-1:0] rw,
                             output logic tail);
        logic [DW-1:0] l_acc;
        logic [DW-1:0] r_acc;
        logic          t;
        l_acc = '0;
        r_acc = '0;
        t     = 1'b0;
        if (exp_q.size() > 0) exp_pair = exp_q.pop_front();
        else                  exp_pair = '0;
        if (inj) exp_q.push_back({inj_l, inj_r});
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < hb; i++) begin
                aud_bclk = 1'b0;
                if (i == 0) aud_daclrck = (h == 0);
                for (int j = 1; j <= 8; j++) begin
                    @(negedge clk);
                    if (inj && h == 0 && i == 0 && j == 2) begin
                        left_dat  = inj_l;
                        right_dat = inj_r;
                        write     = 1'b1;
                    end
                    if (inj && h == 0 && i == 0 && j == 3) write = 1'b0;
                end
                aud_bclk = 1'b1;
                if (i < DW) begin
                    if (h == 0) l_acc = {l_acc[DW-2:0], dacdat};
                    else        r_acc = {r_acc[DW-2:0], dacdat};
                end else begin
                    t = t | dacdat;
                end
                repeat (8) @(negedge clk);
            end
        end
        lw   = l_acc;
        rw   = r_acc;
        tail = t;
    endtask

    task automatic test_reset();
        logic acc;
        n_checks++; if (allowed !== 1'b0) $display("FAIL reset_allowed got %b exp 0", allowed); else n_pass++;
        n_checks++; if (dacdat !== 1'b0) $display("FAIL reset_dacdat got %b exp 0", dacdat); else n_pass++;
        n_checks++; if (used !== 8'd0) $display("FAIL reset_used got %0d exp 0", used); else n_pass++;
        n_checks++; if ({underrun, overflow} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {underrun, overflow}); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (allowed !== 1'b1) $display("FAIL release_allowed got %b exp 1", allowed); else n_pass++;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            aud_bclk = 1'b0;
            repeat (8) @(negedge clk);
            aud_bclk = 1'b1;
            acc = acc | dacdat;
            repeat (8) @(negedge clk);
        end
        n_checks++; if (acc !== 1'b0) $display("FAIL idle_dacdat got %b exp 0", acc); else n_pass++;
    endtask

    task automatic test_basic();
        logic [63:0]   ep;
        logic [DW-1:0] lw, rw;
        logic          tail;
        write_pair(32'h8000_0001, 32'h0000_0003);
        n_checks++; if (used !== 8'd1) $display("FAIL basic_used_pre got %0d exp 1", used); else n_pass++;
        run_frame(36, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if (lw !== 32'h8000_0001) $display("FAIL basic_left got %h exp 80000001", lw); else n_pass++;
        n_checks++; if (rw !== 32'h0000_0003) $display("FAIL basic_right got %h exp 00000003", rw); else n_pass++;
        n_checks++; if ({lw, rw} !== ep) $display("FAIL basic_scoreboard got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if (tail !== 1'b0) $display("FAIL basic_trailing got %b exp 0", tail); else n_pass++;
        n_checks++; if (used !== 8'd0) $display("FAIL basic_used_post got %0d exp 0", used); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL basic_underrun got %b exp 0", underrun); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [63:0]   ep;
        logic [DW-1:0] lw, rw;
        logic          tail;
        run_frame(32, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL underrun_data got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if (underrun !== 1'b1) $display("FAIL underrun_set got %b exp 1", underrun); else n_pass++;
        run_frame(32, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL underrun_data2 got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if (underrun !== 1'b1) $display("FAIL underrun_sticky got %b exp 1", underrun); else n_pass++;
        pulse_clear();
        n_checks++; if (underrun !== 1'b0) $display("FAIL underrun_clear got %b exp 0", underrun); else n_pass++;
    endtask

    task automatic test_full();
        logic [63:0]   ep;
        logic [DW-1:0] lw, rw;
        logic          tail;
        for (int i = 0; i < DEPTH - 1; i++) write_pair($urandom, $urandom);
        n_checks++; if (allowed !== 1'b1) $display("FAIL full_allowed_127 got %b exp 1", allowed); else n_pass++;
        write_pair($urandom, $urandom);
        n_checks++; if (allowed !== 1'b0) $display("FAIL full_allowed_128 got %b exp 0", allowed); else n_pass++;
        n_checks++; if (used !== 8'(exp_q.size())) $display("FAIL full_used got %0d exp %0d", used, exp_q.size()); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL full_overflow_pre got %b exp 0", overflow); else n_pass++;
        write_pair(32'hDEAD_BEEF, 32'hCAFE_F00D);
        n_checks++; if (overflow !== 1'b1) $display("FAIL full_overflow got %b exp 1", overflow); else n_pass++;
        n_checks++; if (used !== 8'd128) $display("FAIL full_used_129 got %0d exp 128", used); else n_pass++;
        run_frame(32, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL full_first_pair got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if (used !== 8'd127) $display("FAIL full_used_pop got %0d exp 127", used); else n_pass++;
        n_checks++; if (allowed !== 1'b1) $display("FAIL full_allowed_pop got %b exp 1", allowed); else n_pass++;
        pulse_clear();
        n_checks++; if ({used, overflow} !== 9'd0) $display("FAIL full_clear got used=%0d ovf=%b exp 0/0", used, overflow); else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [63:0]   ep;
        logic [DW-1:0] lw, rw;
        logic          tail;
        write_pair(32'h1234_5678, 32'h9ABC_DEF0);
        run_frame(32, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL same_first got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if (used !== 8'd1) $display("FAIL same_used got %0d exp 1", used); else n_pass++;
        run_frame(32, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL same_second got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if (used !== 8'd0) $display("FAIL same_used2 got %0d exp 0", used); else n_pass++;
        // Empty FIFO: the pop sees empty, the write still lands.
        run_frame(32, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL empty_same_data got %h exp %h", {lw, rw}, ep); else n_pass++;
        n_checks++; if ({underrun, used} !== {1'b1, 8'd1}) $display("FAIL empty_same_state got un=%b used=%0d exp 1/1", underrun, used); else n_pass++;
        run_frame(32, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL empty_same_next got %h exp %h", {lw, rw}, ep); else n_pass++;
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        logic [63:0]   ep;
        logic [DW-1:0] lw, rw;
        logic          tail;
        logic          acc;
        for (int i = 0; i < 3; i++) write_pair($urandom, $urandom);
        for (int i = 0; i < 5; i++) begin
            aud_bclk = 1'b0;
            if (i == 0) aud_daclrck = 1'b1;
            repeat (8) @(negedge clk);
            aud_bclk = 1'b1;
            repeat (8) @(negedge clk);
        end
        void'(exp_q.pop_front());
        n_checks++; if (used !== 8'(exp_q.size())) $display("FAIL mid_used_pre got %0d exp %0d", used, exp_q.size()); else n_pass++;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++; if ({dacdat, used} !== 9'd0) $display("FAIL mid_reset got dac=%b used=%0d exp 0/0", dacdat, used); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc = 1'b0;
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 27; i++) begin
                aud_bclk = 1'b0;
                if (h == 1 && i == 0) aud_daclrck = 1'b0;
                repeat (8) @(negedge clk);
                aud_bclk = 1'b1;
                acc = acc | dacdat;
                repeat (8) @(negedge clk);
            end
        end
        n_checks++; if (acc !== 1'b0) $display("FAIL mid_no_partial got %b exp 0", acc); else n_pass++;
        write_pair(32'hC001_D00D, 32'h0000_FFFF);
        run_frame(32, 1'b0, '0, '0, ep, lw, rw, tail);
        n_checks++; if ({lw, rw} !== ep) $display("FAIL mid_resume got %h exp %h", {lw, rw}, ep); else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        write       = 1'b0;
        left_dat    = '0;
        right_dat   = '0;
        aud_bclk    = 1'b1;
        aud_daclrck = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_underrun();
        test_full();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
